// File: rtl/pic_ctrl_seq.sv
// pic_ctrl_seq: parametrised 8259A-style interrupt control sequencer.
// Captures requests (edge/level) into IRR, resolves fixed or rotating
// fully-nested priority against ISR, runs the two-pulse INTA handshake
// that drives the vector, and retires ISR bits via specific,
// non-specific or automatic EOI.
// The CPU interrupt output is named cpu_int because `int` is a
// reserved word in SystemVerilog.
module pic_ctrl_seq #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic [NUM_IRQ-1:0]         imr,
  input  logic                       ltim,
  input  logic                       aeoi,
  input  logic                       rotate,
  input  logic [VEC_W-1:0]           vec_base,
  input  logic                       inta,
  input  logic                       eoi_valid,
  input  logic                       eoi_specific,
  input  logic [$clog2(NUM_IRQ)-1:0] eoi_level,
  output logic                       cpu_int,
  output logic [VEC_W-1:0]           data_out,
  output logic                       data_oe,
  output logic [NUM_IRQ-1:0]         irr,
  output logic [NUM_IRQ-1:0]         isr,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK1 = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_irr;
  logic [NUM_IRQ-1:0] r_isr;
  logic               r_inta_q;
  logic [IDX_W-1:0]   r_lp;
  logic [IDX_W-1:0]   r_win;
  logic               r_spur;
  logic               r_int;
  logic [VEC_W-1:0]   r_data_out;
  logic               r_data_oe;

  // Priority datapath
  logic [NUM_IRQ-1:0] w_req;
  logic [NUM_IRQ-1:0] w_req_rot;
  logic [NUM_IRQ-1:0] w_isr_rot;
  logic [IDX_W-1:0]   w_base;
  logic               w_req_any;
  logic               w_isr_any;
  logic [IDX_W-1:0]   w_req_rank;
  logic [IDX_W-1:0]   w_isr_rank;
  logic               w_cand;
  logic [IDX_W-1:0]   w_cand_idx;
  logic [IDX_W-1:0]   w_isr_top_idx;

  // Handshake / EOI control
  logic               w_inta_rise;
  logic               w_ack;
  logic               w_vec_load;
  logic               w_ack2_done;
  logic               w_eoi_hit;
  logic [IDX_W-1:0]   w_eoi_idx;
  logic               w_aeoi_hit;
  logic [NUM_IRQ-1:0] w_ack_set;
  logic [NUM_IRQ-1:0] w_eoi_clr;
  logic [NUM_IRQ-1:0] w_aeoi_clr;
  logic [NUM_IRQ-1:0] w_irr_next;
  logic [NUM_IRQ-1:0] w_isr_next;
  logic [IDX_W-1:0]   w_lp_next;
  logic               w_int_next;
  logic [VEC_W-1:0]   w_vector;

  assign w_req       = r_irr & ~imr;
  assign w_base      = r_lp + IDX_W'(1);
  assign w_inta_rise = inta & ~r_inta_q;

  // Rotate IRR/ISR so that bit 0 is always the current highest priority;
  // power-of-two channel count makes the index sum wrap for free.
  // The same channel index also decodes the one-hot set/clear masks.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
    logic [IDX_W-1:0] w_src;
    assign w_src          = IDX_W'(gi) + w_base;
    assign w_req_rot[gi]  = w_req[w_src];
    assign w_isr_rot[gi]  = r_isr[w_src];
    assign w_ack_set[gi]  = w_ack & w_cand & (w_cand_idx == IDX_W'(gi));
    assign w_eoi_clr[gi]  = w_eoi_hit & (w_eoi_idx == IDX_W'(gi));
    assign w_aeoi_clr[gi] = w_aeoi_hit & (r_win == IDX_W'(gi));
  end

  // Find the highest-priority pending request and in-service rank
  always_comb begin
    w_req_any  = 1'b0;
    w_isr_any  = 1'b0;
    w_req_rank = '0;
    w_isr_rank = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_req_any  = 1'b1;
        w_req_rank = IDX_W'(k);
      end
      if (w_isr_rot[k]) begin
        w_isr_any  = 1'b1;
        w_isr_rank = IDX_W'(k);
      end
    end
  end

  // Fully nested: a request only wins if it outranks everything in service
  assign w_cand        = w_req_any & (~w_isr_any | (w_req_rank < w_isr_rank));
  assign w_cand_idx    = w_req_rank + w_base;
  assign w_isr_top_idx = w_isr_rank + w_base;

  // FSM next-state and handshake strobes
  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_vec_load   = 1'b0;
    w_ack2_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cand) w_state_next = S_PEND;
      end
      S_PEND: begin
        if (w_inta_rise) begin
          w_ack        = 1'b1;
          w_state_next = S_ACK1;
        end else if (!w_cand) begin
          w_state_next = S_IDLE;
        end
      end
      S_ACK1: begin
        if (w_inta_rise) begin
          w_vec_load   = 1'b1;
          w_state_next = S_ACK2;
        end
      end
      S_ACK2: begin
        if (!inta) begin
          w_ack2_done  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // EOI/AEOI clears, acknowledge set (set wins on the same bit), IRR capture
  always_comb begin
    w_eoi_hit  = eoi_valid & (eoi_specific | w_isr_any);
    w_eoi_idx  = eoi_specific ? eoi_level : w_isr_top_idx;
    w_aeoi_hit = w_ack2_done & aeoi & ~r_spur;
    w_isr_next = (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_ack_set;
    if (ltim) begin
      w_irr_next = irq_in & ~w_ack_set;
    end else begin
      w_irr_next = (r_irr & ~w_ack_set) | (irq_in & ~r_irq_q);
    end
    w_lp_next = r_lp;
    if (rotate && w_eoi_hit) begin
      w_lp_next = w_eoi_idx;
    end else if (rotate && w_aeoi_hit) begin
      w_lp_next = r_win;
    end
    w_int_next = w_cand & ~w_ack & ((r_state == S_IDLE) | (r_state == S_PEND));
    // Keep vec_base upper bits, replace the low index bits with the winner
    w_vector   = (vec_base & ~VEC_W'(NUM_IRQ - 1)) | VEC_W'(r_win);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request/service registers, winner latch and vector drive
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_q    <= '0;
      r_inta_q   <= 1'b0;
      r_irr      <= '0;
      r_isr      <= '0;
      r_lp       <= IDX_W'(NUM_IRQ - 1);
      r_win      <= '0;
      r_spur     <= 1'b0;
      r_int      <= 1'b0;
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
    end else begin
      r_irq_q  <= irq_in;
      r_inta_q <= inta;
      r_irr    <= w_irr_next;
      r_isr    <= w_isr_next;
      r_lp     <= w_lp_next;
      r_int    <= w_int_next;
      if (w_ack) begin
        r_win  <= w_cand ? w_cand_idx : IDX_W'(NUM_IRQ - 1);
        r_spur <= ~w_cand;
      end
      if (w_vec_load) begin
        r_data_out <= w_vector;
        r_data_oe  <= 1'b1;
      end else if (w_ack2_done) begin
        r_data_out <= '0;
        r_data_oe  <= 1'b0;
      end
    end
  end

  assign cpu_int  = r_int;
  assign data_out = r_data_out;
  assign data_oe  = r_data_oe;
  assign irr      = r_irr;
  assign isr      = r_isr;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Testbench for pic_ctrl_seq: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pic_ctrl_seq;

  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (8 channels)
  logic       reset;
  logic [7:0] irq_in, imr, vec_base;
  logic       ltim, aeoi, rotate, inta, eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic       cpu_int, data_oe, busy;
  logic [7:0] data_out, irr, isr;

  pic_ctrl_seq #(.NUM_IRQ(8), .VEC_W(8)) u0 (
    .clk(clk), .reset(reset), .irq_in(irq_in), .imr(imr), .ltim(ltim),
    .aeoi(aeoi), .rotate(rotate), .vec_base(vec_base), .inta(inta),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .cpu_int(cpu_int), .data_out(data_out), .data_oe(data_oe), .irr(irr),
    .isr(isr), .busy(busy)
  );

  // Wide DUT (16 channels)
  logic        b_reset, b_inta, b_int, b_doe, b_busy;
  logic [15:0] b_irq, b_irr, b_isr;
  logic [7:0]  b_vec, b_dout;

  pic_ctrl_seq #(.NUM_IRQ(16), .VEC_W(8)) u1 (
    .clk(clk), .reset(b_reset), .irq_in(b_irq), .imr(16'h0000), .ltim(1'b0),
    .aeoi(1'b0), .rotate(1'b0), .vec_base(b_vec), .inta(b_inta),
    .eoi_valid(1'b0), .eoi_specific(1'b0), .eoi_level(4'h0),
    .cpu_int(b_int), .data_out(b_dout), .data_oe(b_doe), .irr(b_irr),
    .isr(b_isr), .busy(b_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_irr, m_isr, m_dout, m_irq_q;
  int         m_lp, m_hs, m_win;
  bit         m_int, m_doe, m_spur, m_inta_q;

  // Walk channels in priority order; a request counts only if it is met
  // before any in-service channel.
  function automatic void prio(input logic [7:0] req, input logic [7:0] srv, input int lp,
                               output bit found, output int idx,
                               output bit sfound, output int sidx);
    found = 0; idx = 0; sfound = 0; sidx = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (lp + 1 + k) % N;
      if (!sfound && srv[c]) begin sfound = 1; sidx = c; end
      if (!found && !sfound && req[c]) begin found = 1; idx = c; end
    end
  endfunction

  always @(posedge clk) begin : model
    bit cf, sf, rise;
    int ci, si, e, new_lp;
    logic [7:0] set_m, clr_m;
    if (reset) begin
      m_irr = 0; m_isr = 0; m_dout = 0; m_irq_q = 0;
      m_lp = N - 1; m_hs = 0; m_win = 0;
      m_int = 0; m_doe = 0; m_spur = 0; m_inta_q = 0;
    end else begin
      prio(m_irr & ~imr, m_isr, m_lp, cf, ci, sf, si);
      rise = inta && !m_inta_q;
      set_m = 0; clr_m = 0; new_lp = m_lp;
      case (m_hs)
        0: begin
          if (m_int && rise) begin
            m_win = cf ? ci : N - 1;
            m_spur = !cf;
            if (cf) set_m[ci] = 1'b1;
            m_hs = 1; m_int = 0;
          end else begin
            m_int = cf;
          end
        end
        1: if (rise) begin
          m_dout = (vec_base & 8'hF8) | 8'(m_win);
          m_doe = 1; m_hs = 2;
        end
        default: if (!inta) begin
          m_dout = 0; m_doe = 0; m_hs = 0;
          if (aeoi && !m_spur) begin
            clr_m[m_win] = 1'b1;
            if (rotate) new_lp = m_win;
          end
        end
      endcase
      if (eoi_valid) begin
        e = eoi_specific ? int'(eoi_level) : (sf ? si : -1);
        if (e >= 0) begin
          clr_m[e] = 1'b1;
          if (rotate) new_lp = e;
        end
      end
      m_isr = (m_isr & ~clr_m) | set_m;
      m_irr = ltim ? (irq_in & ~set_m) : ((m_irr & ~set_m) | (irq_in & ~m_irq_q));
      m_lp = new_lp;
      m_irq_q = irq_in;
      m_inta_q = inta;
    end
  end

  // Every-cycle comparison of the main DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc int",      cpu_int,  m_int);
      check("cyc data_oe",  data_oe,  m_doe);
      check("cyc data_out", data_out, m_dout);
      check("cyc irr",      irr,      m_irr);
      check("cyc isr",      isr,      m_isr);
      check("cyc busy",     busy,     m_int || (m_hs != 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; irq_in = 0; imr = 0; ltim = 0; aeoi = 0; rotate = 0;
    vec_base = 8'h40; inta = 0; eoi_valid = 0; eoi_specific = 0; eoi_level = 0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 0;
  endtask

  task automatic wait_int(input string nm);
    bit ok;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (cpu_int) ok = 1;
      else tick();
    end
    check(nm, ok, 1);
  endtask

  task automatic ack_seq(input string nm, input logic [7:0] exp_vec);
    inta = 1; tick();
    inta = 0; tick();
    inta = 1; tick();
    check({nm, " oe"}, data_oe, 1);
    check({nm, " vec"}, data_out, exp_vec);
    inta = 0; tick();
  endtask

  task automatic eoi(input bit spec, input logic [2:0] lvl);
    eoi_valid = 1; eoi_specific = spec; eoi_level = lvl;
    tick();
    eoi_valid = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    b_reset = 1; b_irq = 0; b_inta = 0; b_vec = 8'h80;
    // A: basic edge capture and two-pulse acknowledge of IR3
    do_reset();
    check("rst irr", irr, 0); check("rst isr", isr, 0); check("rst int", cpu_int, 0);
    check("rst busy", busy, 0); check("rst oe", data_oe, 0); check("rst dout", data_out, 0);
    irq_in = 8'h08; tick();
    check("A irr", irr, 8'h08); check("A int early", cpu_int, 0);
    tick();
    check("A int", cpu_int, 1);
    irq_in = 0;
    inta = 1; tick();
    check("A isr", isr, 8'h08); check("A irr clr", irr, 0);
    check("A int drop", cpu_int, 0); check("A busy", busy, 1);
    inta = 0; tick(); inta = 1; tick();
    check("A oe", data_oe, 1); check("A vec", data_out, 8'h43);
    inta = 0; tick();
    check("A oe off", data_oe, 0); check("A busy off", busy, 0); check("A isr kept", isr, 8'h08);

    // B: fixed priority on simultaneous requests, then non-specific EOI
    do_reset();
    irq_in = 8'h24; tick(); tick();
    ack_seq("B first", 8'h42);
    check("B isr", isr, 8'h04); check("B irr", irr, 8'h20);
    eoi(0, 0);
    check("B eoi isr", isr, 0);
    wait_int("B int again");
    ack_seq("B second", 8'h45);
    check("B isr2", isr, 8'h20);

    // C: fully nested masking by in-service level
    do_reset();
    irq_in = 8'h08; wait_int("C int3");
    ack_seq("C IR3", 8'h43);
    irq_in = 8'h48; tick(); tick(); tick();
    check("C low blocked", cpu_int, 0); check("C irr6", irr, 8'h40);
    irq_in = 8'h4A; tick(); tick();
    check("C nest int", cpu_int, 1);
    ack_seq("C IR1", 8'h41);
    check("C isr", isr, 8'h0A);

    // D: automatic EOI with rotation
    do_reset();
    rotate = 1; aeoi = 1;
    irq_in = 8'h01; wait_int("D int0");
    ack_seq("D IR0", 8'h40);
    check("D aeoi isr", isr, 0);
    irq_in = 0; tick();
    irq_in = 8'h03; wait_int("D int1");
    ack_seq("D IR1 wins", 8'h41);

    // E: level mode line drop, then spurious acknowledge
    do_reset();
    ltim = 1;
    irq_in = 8'h10; tick();
    check("E irr", irr, 8'h10);
    tick();
    check("E int", cpu_int, 1); check("E busy", busy, 1);
    irq_in = 0; tick();
    check("E int hold", cpu_int, 1);
    tick();
    check("E int lost", cpu_int, 0); check("E idle", busy, 0);
    irq_in = 8'h10; tick(); tick();
    irq_in = 0; tick();
    inta = 1; tick();
    check("E spur busy", busy, 1); check("E spur isr", isr, 0);
    inta = 0; tick(); inta = 1; tick();
    check("E spur vec", data_out, 8'h47); check("E spur oe", data_oe, 1);
    inta = 0; tick();
    check("E spur isr end", isr, 0); check("E spur idle", busy, 0);

    // F: reset in the middle of ACK2
    do_reset();
    irq_in = 8'h10; wait_int("F int");
    inta = 1; tick(); inta = 0; tick(); inta = 1; tick();
    check("F oe", data_oe, 1); check("F isr", isr, 8'h10);
    reset = 1; tick();
    check("F rst oe", data_oe, 0); check("F rst isr", isr, 0); check("F rst busy", busy, 0);
    reset = 0; inta = 0; irq_in = 0; tick();

    // G: 16-channel instance, vector 0x80 | 12
    tick(); b_reset = 0;
    b_irq = 16'h1000; tick();
    check("G irr", b_irr, 16'h1000);
    tick();
    check("G int", b_int, 1);
    b_inta = 1; tick();
    check("G isr", b_isr, 16'h1000);
    b_inta = 0; tick(); b_inta = 1; tick();
    check("G vec", b_dout, 8'h8C); check("G oe", b_doe, 1);
    b_inta = 0; tick();
    check("G oe off", b_doe, 0); check("G idle", b_busy, 0);

    // R: randomized traffic, model-checked every cycle
    do_reset();
    for (int seg = 0; seg < 15; seg++) begin
      ltim = 1'($urandom_range(0, 1));
      aeoi = 1'($urandom_range(0, 1));
      rotate = 1'($urandom_range(0, 1));
      vec_base = 8'($urandom);
      imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 5) == 0) irq_in = irq_in ^ 8'(1 << $urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) inta = ~inta;
        eoi_valid = ($urandom_range(0, 15) == 0);
        eoi_specific = 1'($urandom_range(0, 1));
        eoi_level = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 40) == 0) imr = 8'($urandom & $urandom);
        reset = ($urandom_range(0, 499) == 0);
        tick();
      end
    end
    reset = 0; eoi_valid = 0; inta = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_ctrl_seq.md
Name: pic_ctrl_seq

Overview:
- Parametrised interrupt control sequencer for the 8259A-style PIC. It is the successor to the fixed 8-input control logic.
- Handles NUM_IRQ request lines and captures requests in edge or level mode.
- Resolves priority in fixed or rotating mode and runs the two-pulse INTA handshake that drives the vector.
- Maintains IRR/ISR with specific, non-specific and automatic EOI.
- Sits between the request pins and the data-bus buffer. Mode bits come from the ICW/OCW register file.

Parameters:
- NUM_IRQ, 8, number of request channels. Must be a power of 2, from 2 to 32.
- VEC_W, 8, width of the vector/data bus. Must satisfy VEC_W > IDX_W.
- IDX_W, $clog2(NUM_IRQ), derived channel-index width. Not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- irq_in  in  NUM_IRQ  raw request lines; bit 0 is IR0
- imr  in  NUM_IRQ  mask register; 1 masks the channel
- ltim  in  1  1 = level-triggered, 0 = edge-triggered
- aeoi  in  1  automatic EOI at the end of the second INTA
- rotate  in  1  rotate priority on every EOI (including AEOI)
- vec_base  in  VEC_W  vector base; only bits [VEC_W-1:IDX_W] are used
- inta  in  1  active-high acknowledge strobe (level, synchronous to clk)
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI
- eoi_level  in  IDX_W  channel for specific EOI
- int  out  1  interrupt request to the CPU
- data_out  out  VEC_W  vector byte
- data_oe  out  1  data bus drive enable
- irr  out  NUM_IRQ  interrupt request register
- isr  out  NUM_IRQ  in-service register
- busy  out  1  FSM not in IDLE

Behaviour:
Reset:
- While reset=1 at a clock edge, all of the following clear to 0: int, data_out, data_oe, irr, isr, busy, irq_q, inta_q.
- FSM goes to IDLE and lowest-priority pointer lp goes to NUM_IRQ-1.
- Reset mid-handshake aborts immediately with no ISR side effects.

Request capture:
- irq_q <= irq_in every cycle.
- Edge mode: irr[i] is set when irq_in[i] & ~irq_q[i], and holds until acknowledged.
- Level mode: irr[i] follows irq_in[i] with one cycle of latency, except on the acknowledge cycle, where it is forced to 0.
- A line already high at reset release sets irr in edge mode.

Priority:
- Order starts at (lp+1) mod NUM_IRQ (highest) and wraps to lp (lowest).
- The candidate is the highest-priority bit of irr & ~imr that is strictly higher than the highest isr bit (fully nested).
- int is registered: high the cycle after a candidate exists while in IDLE/PEND.
- Latency: irq_in rises at edge t → irr=1 after t+1 → int=1 after t+2.

FSM:
- IDLE → PEND when a candidate exists.
- PEND, candidate lost (mask, or level line dropped): int=0, go to IDLE.
- PEND, inta rising edge (inta & ~inta_q):
  - Latch the winner and set isr[w].
  - Clear irr[w] and drop int.
  - Go to ACK1.
- PEND, inta rising edge with no candidate: spurious acknowledge. Winner = NUM_IRQ-1, no isr set, go to ACK1.
- ACK1, second inta rising edge:
  - data_out = {vec_base[VEC_W-1:IDX_W], w} and data_oe=1, registered (visible the cycle after the edge).
  - Go to ACK2.
- ACK2, while inta=1: hold data_oe.
- ACK2, inta falls:
  - data_oe=0 and data_out=0.
  - If aeoi and not spurious: clear isr[w], and set lp=w if rotate.
  - Go to IDLE.
- inta edges seen in IDLE are ignored. busy=1 in PEND/ACK1/ACK2.

EOI:
- eoi_valid, non-specific: clears the highest-priority set isr bit. No-op if isr=0.
- eoi_valid, specific: clears isr[eoi_level].
- If rotate, lp = the cleared index.
- EOI is evaluated on the pre-update isr. If it coincides with an acknowledge set, both apply; on the same bit, the set wins.

Width rule:
- Vector low IDX_W bits = channel index; upper bits come from vec_base.

Test Plan:
- Reset, edge mode, pulse irq_in[3] → irr=0x08 after 1 cycle, int=1 after 2. Two inta pulses with vec_base=0x40 → data_out=0x43 with data_oe=1 during the 2nd pulse; isr=0x08, irr=0, int=0.
- Set irq_in 0x24 simultaneously, fixed priority → first ack vector index 2. After a non-specific EOI, index 5 is served.
- isr=0x08 in service, raise irq_in[6] → int stays 0. Raise irq_in[1] → int=1 (nesting).
- rotate=1, aeoi=1, serve IR0 → after the 2nd inta falls, isr=0 and lp=0. Simultaneous IR0 and IR1 → IR1 wins.
- Level mode: drop irq_in[4] while in PEND → int=0, FSM in IDLE. Spurious inta with NUM_IRQ=8 → vector base|7, isr unchanged.
- NUM_IRQ=16, VEC_W=8, vec_base=0x80, irq_in[12] → vector 0x8C. Assert reset during ACK2 → data_oe=0, isr=0, busy=0 next cycle.
